// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg: shared widths, FSM state type and one-hot check for the ring counter decoder
package ring_counter_pkg;
  localparam int DEFAULT_COUNT_WIDTH = 8;
  localparam int DEFAULT_REV_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
  function automatic logic is_one_hot(input logic [DEFAULT_COUNT_WIDTH-1:0] v);
    return (|v) && !(|(v & (v - DEFAULT_COUNT_WIDTH'(1))));
  endfunction
endpackage

// File: rtl/onehot_to_binary.sv
// onehot_to_binary: index of the set bit of a one-hot vector, plus a flag that the vector is one-hot
module onehot_to_binary #(
  parameter int WIDTH = 8,
  localparam int POS_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     onehot,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 legal
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) pos = onehot[i] ? pos | POS_WIDTH'(i) : pos;
  end
  assign legal = (|onehot) && !(|(onehot & (onehot - WIDTH'(1))));
endmodule

// File: rtl/ring_counter_decoder.sv
// ring_counter_decoder: checks a one-hot ring count, reports position, revolutions and sticky step/illegal flags on tri-state outputs
module ring_counter_decoder
  import ring_counter_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int REV_WIDTH = DEFAULT_REV_WIDTH,
  localparam int POS_WIDTH = $clog2(COUNT_WIDTH)
) (
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  input  logic                   Enable_In,
  input  logic [COUNT_WIDTH-1:0] Ring_Count_In,
  input  logic                   Counter_Running_Flag_In,
  input  logic                   Clear_Error_Command_In,
  output logic [POS_WIDTH-1:0]   Position_Out,
  output logic                   Position_Valid_Out,
  output logic [REV_WIDTH-1:0]   Revolution_Count_Out,
  output logic                   Wrap_Pulse_Out,
  output logic                   Illegal_Code_Flag_Out,
  output logic                   Step_Error_Flag_Out
);
  logic [COUNT_WIDTH-1:0] s_q, p_q, p_d, rot;
  logic r_q, c_q, s_vld_q, legal, p_legal;
  logic ill_q, ill_d, stp_q, stp_d, wrap_q, wrap_d, new_ill, new_stp;
  logic [REV_WIDTH-1:0] rev_q, rev_d;
  logic [POS_WIDTH-1:0] pos;
  state_t st_q, st_d;
  onehot_to_binary #(.WIDTH(COUNT_WIDTH)) u_enc (
    .onehot(p_q),
    .pos(pos),
    .legal(p_legal)
  );
  assign rot = {p_q[COUNT_WIDTH-2:0], p_q[COUNT_WIDTH-1]};
  assign legal = is_one_hot(s_q);
  always_comb begin
    st_d = st_q;
    p_d = p_q;
    rev_d = rev_q;
    wrap_d = 1'b0;
    new_ill = 1'b0;
    new_stp = 1'b0;
    if (s_vld_q)
      case (st_q)
        IDLE: begin
          new_ill = !legal;
          p_d = legal ? s_q : p_q;
          st_d = legal ? TRACK : FAULT;
        end
        TRACK: begin
          if (!legal) begin
            new_ill = 1'b1;
            st_d = FAULT;
          end else if (s_q != p_q) begin
            p_d = s_q;
            if (r_q && s_q == rot) begin
              wrap_d = p_q[COUNT_WIDTH-1];
              rev_d = rev_q + REV_WIDTH'(p_q[COUNT_WIDTH-1]);
            end else new_stp = 1'b1;
          end
        end
        FAULT: begin
          new_ill = !legal;
          st_d = c_q ? IDLE : FAULT;
        end
        default: st_d = IDLE;
      endcase
    ill_d = new_ill || (ill_q && !c_q);
    stp_d = new_stp || (stp_q && !c_q);
  end
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      s_q <= '0;
      r_q <= 1'b0;
      c_q <= 1'b0;
      s_vld_q <= 1'b0;
      p_q <= '0;
      st_q <= IDLE;
      rev_q <= '0;
      wrap_q <= 1'b0;
      ill_q <= 1'b0;
      stp_q <= 1'b0;
    end else begin
      s_q <= Ring_Count_In;
      r_q <= Counter_Running_Flag_In;
      c_q <= Clear_Error_Command_In;
      s_vld_q <= 1'b1;
      p_q <= p_d;
      st_q <= st_d;
      rev_q <= rev_d;
      wrap_q <= wrap_d;
      ill_q <= ill_d;
      stp_q <= stp_d;
    end
  end
  assign Position_Out = Enable_In ? pos : 'z;
  assign Position_Valid_Out = Enable_In ? (st_q == TRACK) && p_legal : 1'bz;
  assign Revolution_Count_Out = Enable_In ? rev_q : 'z;
  assign Wrap_Pulse_Out = Enable_In ? wrap_q : 1'bz;
  assign Illegal_Code_Flag_Out = Enable_In ? ill_q : 1'bz;
  assign Step_Error_Flag_Out = Enable_In ? stp_q : 1'bz;
endmodule

// File: tb/tb_ring_counter_decoder.sv
// tb_ring_counter_decoder: directed self-checking bench for ring_counter_decoder
module tb_ring_counter_decoder;
  logic tb_Clk_In = 1'b0;
  logic tb_Reset_In = 1'b1;
  logic tb_Enable_In = 1'b1;
  logic tb_Running_In = 1'b0;
  logic tb_Clear_In = 1'b0;
  logic [7:0] tb_Ring_In = 8'h01;
  wire [2:0] tb_Position_Out;
  wire [7:0] tb_Rev_Out;
  wire tb_Valid_Out, tb_Wrap_Out, tb_Illegal_Out, tb_Step_Out;
  int checks = 0;
  int failures = 0;
  always #5 tb_Clk_In = ~tb_Clk_In;
  for (genvar g = 0; g < 3; g++) begin : g_pu_pos
    pullup (tb_Position_Out[g]);
  end
  for (genvar g = 0; g < 8; g++) begin : g_pu_rev
    pullup (tb_Rev_Out[g]);
  end
  pullup (tb_Valid_Out);
  pullup (tb_Wrap_Out);
  pullup (tb_Illegal_Out);
  pullup (tb_Step_Out);
  ring_counter_decoder dut (
    .Clk_In(tb_Clk_In),
    .Reset_In(tb_Reset_In),
    .Enable_In(tb_Enable_In),
    .Ring_Count_In(tb_Ring_In),
    .Counter_Running_Flag_In(tb_Running_In),
    .Clear_Error_Command_In(tb_Clear_In),
    .Position_Out(tb_Position_Out),
    .Position_Valid_Out(tb_Valid_Out),
    .Revolution_Count_Out(tb_Rev_Out),
    .Wrap_Pulse_Out(tb_Wrap_Out),
    .Illegal_Code_Flag_Out(tb_Illegal_Out),
    .Step_Error_Flag_Out(tb_Step_Out)
  );
  task automatic tick();
    @(posedge tb_Clk_In);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [2:0] p, input logic v, input logic [7:0] c,
                         input logic w, input logic il, input logic st);
    chk({tag, ".pos"}, 32'(tb_Position_Out), 32'(p));
    chk({tag, ".valid"}, 32'(tb_Valid_Out), 32'(v));
    chk({tag, ".revs"}, 32'(tb_Rev_Out), 32'(c));
    chk({tag, ".wrap"}, 32'(tb_Wrap_Out), 32'(w));
    chk({tag, ".illegal"}, 32'(tb_Illegal_Out), 32'(il));
    chk({tag, ".step"}, 32'(tb_Step_Out), 32'(st));
  endtask
  initial begin
    tick();
    chk_all("reset", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tb_Reset_In = 1'b0;
    tick();
    tick();
    chk_all("first_track", 3'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    tb_Running_In = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tb_Ring_In = 8'(1 << (i % 8));
      tick();
      chk($sformatf("seq%0d.pos", i), 32'(tb_Position_Out), (i == 0) ? 32'd0 : 32'((i - 1) % 8));
      chk($sformatf("seq%0d.wrap", i), 32'(tb_Wrap_Out), 32'(i == 9));
      chk($sformatf("seq%0d.revs", i), 32'(tb_Rev_Out), 32'(i >= 9));
    end
    tick();
    chk_all("seq_end", 3'd1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tb_Ring_In = 8'h04;
    tick();
    tick();
    chk_all("at_04", 3'd2, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tb_Ring_In = 8'h10;
    tick();
    tick();
    chk_all("step_err", 3'd4, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1);
    tb_Clear_In = 1'b1;
    tick();
    tb_Clear_In = 1'b0;
    tick();
    chk_all("step_clear", 3'd4, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tb_Ring_In = 8'h03;
    tick();
    tick();
    chk_all("multi_hot", 3'd4, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
    tb_Ring_In = 8'h00;
    tick();
    tick();
    chk_all("zero_code", 3'd4, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
    tb_Clear_In = 1'b1;
    tick();
    tick();
    chk_all("clear_vs_err", 3'd4, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
    tb_Ring_In = 8'h01;
    tick();
    tick();
    chk_all("fault_to_idle", 3'd4, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    tb_Clear_In = 1'b0;
    tick();
    chk_all("idle_to_track", 3'd0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 255 * 8; k++) begin
      tb_Ring_In = 8'(1 << ((k + 1) % 8));
      tick();
    end
    chk_all("revs_255", 3'd7, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    tb_Ring_In = 8'h02;
    tick();
    chk_all("revs_rollover", 3'd0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("after_rollover", 3'd1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int j = 2; j < 8; j++) begin
      tb_Ring_In = 8'(1 << j);
      tick();
    end
    tb_Ring_In = 8'h01;
    for (int h = 0; h < 4; h++) begin
      tick();
      chk($sformatf("hold%0d.wrap", h), 32'(tb_Wrap_Out), 32'(h == 1));
    end
    chk_all("hold_end", 3'd0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tb_Ring_In = 8'h02;
    tick();
    tb_Ring_In = 8'h40;
    tick();
    tick();
    chk_all("pre_reset_step", 3'd6, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1);
    tb_Reset_In = 1'b1;
    tb_Ring_In = 8'h04;
    tick();
    chk_all("mid_reset", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tb_Reset_In = 1'b0;
    tick();
    tick();
    chk_all("post_reset", 3'd2, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    tb_Enable_In = 1'b0;
    #1;
    chk_all("disable_now", 3'h7, 1'b1, 8'hff, 1'b1, 1'b1, 1'b1);
    for (int j = 3; j < 10; j++) begin
      tb_Ring_In = 8'(1 << (j % 8));
      tick();
      chk_all($sformatf("disabled%0d", j), 3'h7, 1'b1, 8'hff, 1'b1, 1'b1, 1'b1);
    end
    tick();
    tb_Enable_In = 1'b1;
    #1;
    chk_all("reenable", 3'd1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
